// File: rtl/sobel_edge_param.sv
// sobel_edge_param: streaming 3x3 Sobel edge detector (L1 or squared-L2 threshold); define SOBEL_DIR_OUT_EN to add post_img_dir
module sobel_edge_param #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_y,
    input  logic              cfg_mode,
    input  logic [DATA_W+2:0] cfg_threshold,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
`ifdef SOBEL_DIR_OUT_EN
    output logic [1:0]        post_img_dir,
`endif
    output logic              post_img_bit
);
    localparam int SW = DATA_W + 2;
    localparam int MW = 2 * DATA_W + 6;
    localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(IMG_W - 1);

    logic [DATA_W-1:0] line1 [IMG_W];
    logic [DATA_W-1:0] line2 [IMG_W];
    logic [DATA_W-1:0] rd1_q, rd2_q;
    logic              vs_prev_q, vs_prev_d, hs_prev_q, hs_prev_d;
    logic [5:0]        vs_q, vs_d, hs_q, hs_d, ce_q, ce_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic              full_q, full_d, armed_q, armed_d;
    logic [1:0]        row_q, row_d;
    logic              mode_q, mode_d;
    logic [DATA_W+2:0] thr_q, thr_d;
    logic              sh1_q, sh1_d, v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic              v4_q, v4_d, v5_q, v5_d, bit_q, bit_d;
    logic [DATA_W-1:0] y1_q, y1_d;
    logic [DATA_W-1:0] p_q [9];
    logic [DATA_W-1:0] p_d [9];
    logic [DATA_W-1:0] win_in [3];
    logic [SW-1:0]     px_q, px_d, nx_q, nx_d, py_q, py_d, ny_q, ny_d;
    logic [SW-1:0]     ax_q, ax_d, ay_q, ay_d;
    logic [MW-1:0]     m_q, m_d, axw, ayw, thw, thr_cmp;
    logic              acc, vs_rise, hs_fall;

    // Line buffers: L1 holds the previous line, L2 the one before; read-before-write at the same column
    always_ff @(posedge clk) begin
        if (acc) begin
            line1[col_q] <= per_img_y;
            line2[col_q] <= line1[col_q];
            rd1_q        <= line1[col_q];
            rd2_q        <= line2[col_q];
        end
    end

    // Counters, config shadow, window shift and the arithmetic pipeline
    always_comb begin
        acc       = per_frame_href && per_frame_clken && !full_q;
        vs_rise   = per_frame_vsync && !vs_prev_q;
        hs_fall   = hs_prev_q && !per_frame_href;
        vs_prev_d = per_frame_vsync;
        hs_prev_d = per_frame_href;
        vs_d      = {vs_q[4:0], per_frame_vsync};
        hs_d      = {hs_q[4:0], per_frame_href};
        ce_d      = {ce_q[4:0], per_frame_clken};
        col_d     = hs_fall ? '0 : (acc && col_q != COL_MAX) ? col_q + ADDR_W'(1) : col_q;
        full_d    = hs_fall ? 1'b0 : (acc && col_q == COL_MAX) ? 1'b1 : full_q;
        row_d     = vs_rise ? 2'd0 : (hs_fall && row_q != 2'd2) ? row_q + 2'd1 : row_q;
        armed_d   = armed_q || vs_rise;
        mode_d    = vs_rise ? cfg_mode : mode_q;
        thr_d     = vs_rise ? cfg_threshold : thr_q;
        sh1_d     = acc;
        v1_d      = acc && armed_q && row_q == 2'd2 && col_q >= ADDR_W'(2);
        y1_d      = per_img_y;
        win_in[0] = rd2_q;
        win_in[1] = rd1_q;
        win_in[2] = y1_q;
        for (int i = 0; i < 3; i++) begin
            p_d[3*i]   = sh1_q ? p_q[3*i+1] : p_q[3*i];
            p_d[3*i+1] = sh1_q ? p_q[3*i+2] : p_q[3*i+1];
            p_d[3*i+2] = sh1_q ? win_in[i]  : p_q[3*i+2];
        end
        v2_d    = v1_q;
        px_d    = SW'(p_q[2]) + {1'b0, p_q[5], 1'b0} + SW'(p_q[8]);
        nx_d    = SW'(p_q[0]) + {1'b0, p_q[3], 1'b0} + SW'(p_q[6]);
        py_d    = SW'(p_q[6]) + {1'b0, p_q[7], 1'b0} + SW'(p_q[8]);
        ny_d    = SW'(p_q[0]) + {1'b0, p_q[1], 1'b0} + SW'(p_q[2]);
        v3_d    = v2_q;
        ax_d    = (px_q < nx_q) ? nx_q - px_q : px_q - nx_q;
        ay_d    = (py_q < ny_q) ? ny_q - py_q : py_q - ny_q;
        v4_d    = v3_q;
        axw     = MW'(ax_q);
        ayw     = MW'(ay_q);
        thw     = MW'(thr_q);
        m_d     = mode_q ? axw * axw + ayw * ayw : axw + ayw;
        v5_d    = v4_q;
        thr_cmp = mode_q ? thw * thw : thw;
        bit_d   = v5_q && hs_q[4] && m_q >= thr_cmp;
    end

    // State registers; RAM contents are left unreset since the validity rule masks them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_q      <= '0;
            hs_q      <= '0;
            ce_q      <= '0;
            col_q     <= '0;
            full_q    <= 1'b0;
            row_q     <= '0;
            armed_q   <= 1'b0;
            mode_q    <= 1'b0;
            thr_q     <= '0;
            sh1_q     <= 1'b0;
            v1_q      <= 1'b0;
            y1_q      <= '0;
            for (int i = 0; i < 9; i++) p_q[i] <= '0;
            v2_q      <= 1'b0;
            px_q      <= '0;
            nx_q      <= '0;
            py_q      <= '0;
            ny_q      <= '0;
            v3_q      <= 1'b0;
            ax_q      <= '0;
            ay_q      <= '0;
            v4_q      <= 1'b0;
            m_q       <= '0;
            v5_q      <= 1'b0;
            bit_q     <= 1'b0;
        end else begin
            vs_prev_q <= vs_prev_d;
            hs_prev_q <= hs_prev_d;
            vs_q      <= vs_d;
            hs_q      <= hs_d;
            ce_q      <= ce_d;
            col_q     <= col_d;
            full_q    <= full_d;
            row_q     <= row_d;
            armed_q   <= armed_d;
            mode_q    <= mode_d;
            thr_q     <= thr_d;
            sh1_q     <= sh1_d;
            v1_q      <= v1_d;
            y1_q      <= y1_d;
            for (int i = 0; i < 9; i++) p_q[i] <= p_d[i];
            v2_q      <= v2_d;
            px_q      <= px_d;
            nx_q      <= nx_d;
            py_q      <= py_d;
            ny_q      <= ny_d;
            v3_q      <= v3_d;
            ax_q      <= ax_d;
            ay_q      <= ay_d;
            v4_q      <= v4_d;
            m_q       <= m_d;
            v5_q      <= v5_d;
            bit_q     <= bit_d;
        end
    end

    assign post_frame_vsync = vs_q[5];
    assign post_frame_href  = hs_q[5];
    assign post_frame_clken = ce_q[5];
    assign post_img_bit     = bit_q;

`ifdef SOBEL_DIR_OUT_EN
    logic       sx_q, sx_d, sy_q, sy_d;
    logic [1:0] dir5_q, dir5_d, dir_q, dir_d;

    // Direction: signs captured with the absolute values, quantised beside the magnitude, zeroed off-edge
    always_comb begin
        sx_d   = px_q < nx_q;
        sy_d   = py_q < ny_q;
        dir5_d = ({1'b0, ax_q} >= {ay_q, 1'b0}) ? 2'd0 :
                 ({1'b0, ay_q} >= {ax_q, 1'b0}) ? 2'd1 :
                 (sx_q == sy_q) ? 2'd2 : 2'd3;
        dir_d  = bit_d ? dir5_q : 2'd0;
    end

    // Direction registers, aligned with post_img_bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx_q   <= 1'b0;
            sy_q   <= 1'b0;
            dir5_q <= '0;
            dir_q  <= '0;
        end else begin
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            dir5_q <= dir5_d;
            dir_q  <= dir_d;
        end
    end

    assign post_img_dir = dir_q;
`endif
endmodule

// File: doc/sobel_edge_param.md
# sobel_edge_param

Parametrised Sobel edge detector for the licence-plate image pipeline, replacing the fixed 8-bit, CORDIC-based detector. It takes a streamed grayscale frame and builds its own 3x3 window from internal line buffers. It computes signed horizontal and vertical gradients, then thresholds either the L1 magnitude or the exact squared L2 magnitude, with no square-root IP. It sits between the grayscale conversion and the binary morphology/plate-location stages.

## Interface
- DATA_W, 8, pixel width in bits
- IMG_W, 640, maximum active pixels per line; this is the line-buffer depth
- ADDR_W, 10, column counter width; must satisfy 2^ADDR_W >= IMG_W
- clk  in  1  pixel clock; everything is sampled on its rising edge
- rst_n  in  1  asynchronous active-low reset
- per_frame_vsync  in  1  frame sync, active high
- per_frame_href  in  1  line valid
- per_frame_clken  in  1  pixel valid
- per_img_y  in  DATA_W  grayscale pixel
- cfg_mode  in  1  0 = L1 magnitude (|gx|+|gy|), 1 = squared L2 magnitude
- cfg_threshold  in  DATA_W+3  edge threshold
- post_frame_vsync  out  1  vsync delayed by 6 clk
- post_frame_href  out  1  href delayed by 6 clk
- post_frame_clken  out  1  clken delayed by 6 clk
- post_img_bit  out  1  1 = edge
- post_img_dir  out  2  quantised gradient direction; present only when SOBEL_DIR_OUT_EN is defined

## Operation
- Counters
  - col increments on each clken while href is high; it saturates at IMG_W-1, and extra pixels are neither written nor evaluated.
  - col clears on the href falling edge.
  - row increments on the href falling edge and clears on the vsync rising edge.
- Line buffers: two simple dual-port RAMs, IMG_W x DATA_W.
  - On clken, read lines L1 and L2 at address col.
  - Write per_img_y into L1 and the old L1 data into L2.
  - This forms the 3-column shift window p11..p33, where p33 is the newest pixel.
- Gradients, unsigned operands, DATA_W+2-bit sums:
  - gx = (p13 + 2·p23 + p33) − (p11 + 2·p21 + p31)
  - gy = (p31 + 2·p32 + p33) − (p11 + 2·p12 + p13)
  - The absolute values ax and ay are DATA_W+2 bits wide and retain the sign bits sx and sy.
- Magnitude
  - Mode 0: m = ax + ay (DATA_W+3 bits); edge = m >= thr.
  - Mode 1: m = ax² + ay² (2·DATA_W+5 bits); edge = m >= thr·thr, computed at full width with no truncation.
- Window validity: the result is forced to 0 unless row >= 2 and col >= 2 for the pixel that completes the window. The first two lines and first two columns of each frame therefore output 0.
- Output gating: post_img_bit = 0 whenever post_frame_href = 0.
- Config shadowing: cfg_mode and cfg_threshold are captured into shadow registers on the vsync rising edge. Changes mid-frame take effect at the next frame.
- Output geometry: the output pixel is the window centre, which is spatially offset by (−1 row, −1 col) from the input pixel emitted at the same relative position.

## Timing
- Fixed latency: exactly 6 clk from the input clken cycle to the corresponding post_* cycle.
  1. Line-buffer read/window shift.
  2. Window register.
  3. Partial sums.
  4. Absolute difference.
  5. Magnitude.
  6. Compare/register.
- The pipeline advances every clk regardless of clken; sync signals use 6-stage shift registers.
- Back-to-back clken is supported, with no stalls and no backpressure.
- Reset values:
  - All post_* outputs are 0.
  - Counters, shift registers and shadow registers are 0; shadow values are mode 0 and threshold 0.
  - RAM contents are not reset. Stale data is masked by the validity rule.
- Reset asserted mid-frame: outputs reach 0 immediately (asynchronously). After release, output stays 0 until a vsync rising edge restarts row counting.

## Configuration
- SOBEL_DIR_OUT_EN, when defined, adds the post_img_dir port and one register stage, aligned with post_img_bit:
  - 0 if ax >= 2·ay
  - 1 if ay >= 2·ax
  - 2 if sx == sy
  - otherwise 3
  - Forced to 0 whenever post_img_bit = 0.
- Without the macro, the port and logic are absent; latency is unchanged.

## Test plan
- Flat frame of value 128, 16x8 lines, threshold 1 → post_img_bit is 0 for every pixel; post_* syncs equal the inputs delayed by exactly 6 clk.
- Vertical step (columns 0–7 = 0, columns 8+ = 255), mode 0, threshold 250 → output 1 only at centre columns 7 and 8 (gx = 1020, gy = 0) for rows ≥ 1; 0 in output rows 0 and column 0; post_img_dir = 0 when the macro is enabled.
- Same frame, mode 1, threshold 1021 → all 0 (1020² < 1021²); threshold 1020 → 1 at columns 7 and 8.
- Diagonal step with thr_L1 = 1000 → the L1 sum of about 1530 marks an edge; post_img_dir is 2 or 3 according to the gradient signs.
- cfg_mode toggled mid-frame → the current frame is unaffected; the next frame uses the new mode.
- rst_n pulsed low mid-line → all outputs are 0 within the same cycle; the next full frame after a vsync matches the golden model bit-exactly.
